icache_nway_datapath: RTL and testbench
=======================================

// Module: icache_nway_datapath
// PURPOSE
//  Parametrised N-way set-associative instruction-cache datapath plus control for the fetch stage.
//  - Accepts fetch lookups and returns one word with 1-cycle hit latency.
//  - On a miss, runs a line refill over a req/ack handshake to imem.
//  - Victim selection: per-set round-robin.
//  - Invalidation: a sequential flush that walks every set.
//  - NUM_WAYS=1 degenerates to a direct-mapped cache.
// PARAMETERS
//  ADDR_W    32   fetch/refill address width (bits)
//  DATA_W    32   fetch word width (bits)
//  LINE_W    128  cache line width (bits); power of 2, multiple of DATA_W
//  NUM_SETS  128  sets; power of 2
//  NUM_WAYS  2    ways per set; power of 2, >=1
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        synchronous reset, active-high
//  flush_i        in   1        invalidate whole cache (pulse)
//  lookup_req_i   in   1        fetch request; accepted when ready_o=1
//  addr_i         in   ADDR_W   fetch byte address
//  ready_o        out  1        block can accept a lookup this cycle
//  data_valid_o   out  1        data_o valid (1-cycle pulse)
//  hit_o          out  1        qualifies data_valid_o: 1=hit, 0=served by refill
//  data_o         out  DATA_W   fetched word
//  refill_req_o   out  1        line refill request to imem
//  refill_addr_o  out  ADDR_W   line-aligned refill address
//  refill_ack_i   in   1        imem returns line this cycle
//  refill_data_i  in   LINE_W   refill line
// BEHAVIOUR
//  Address split:
//  - OFF_W = log2(LINE_W/8); IDX_W = log2(NUM_SETS); TAG_W = ADDR_W-IDX_W-OFF_W.
//  - word select = addr[OFF_W-1:log2(DATA_W/8)].
//  - Word 0 is refill_data_i[DATA_W-1:0].
//  FSM states: FLUSH, IDLE, MISS, REPLY.
//  - ready_o=1 only in IDLE.
//  Reset (rst_i=1):
//  - state<=FLUSH, flush index<=0.
//  - All outputs 0 (ready_o, data_valid_o, hit_o, refill_req_o, data_o, refill_addr_o).
//  - Abandons any refill in progress; refill_req_o is 0 the cycle after reset is sampled.
//  - Data/tag arrays are not reset; correctness relies on valid bits only.
//  FLUSH:
//  - Each cycle clears valid[idx][all ways] and rr_ptr[idx]; idx++.
//  - After idx=NUM_SETS-1, goes to IDLE. Duration is exactly NUM_SETS cycles.
//  - flush_i asserted during FLUSH is ignored.
//  IDLE:
//  - flush_i has priority over lookup_req_i: state<=FLUSH and the lookup is dropped.
//  - On an accepted lookup (cycle 0): latch addr; compare tags of all ways of the set.
//  - Hit: cycle 1 data_valid_o=1, hit_o=1, data_o=word; stay IDLE (back-to-back lookups allowed).
//  - Miss: cycle 1 state=MISS, refill_req_o=1, refill_addr_o={tag,idx,OFF_W'0}.
//  - Multi-way hit is illegal (assertion); the lowest-numbered way wins.
//  MISS:
//  - refill_req_o held high until refill_ack_i is sampled high.
//  - refill_ack_i is ignored whenever refill_req_o=0.
//  - Ack may arrive in the first MISS cycle.
//  - Ack cycle: write refill_data_i and tag, set valid, into victim way; go to REPLY.
//  - Victim = lowest invalid way, else rr_ptr[idx]. rr_ptr[idx] increments mod NUM_WAYS only when a valid way is evicted.
//  REPLY (1 cycle):
//  - data_valid_o=1, hit_o=0, data_o=requested word from refill line.
//  - Then go to IDLE, or to FLUSH if a flush is pending.
//  Flush during MISS/REPLY: latched into flush_pend; the refill and reply still complete, then FLUSH runs (the new line is invalidated).
//  data_valid_o/hit_o are single-cycle pulses; data_o holds its last value otherwise.
// STRUCTURE
//  Package (cache_defs) gains:
//  - state enum type_icache_nway_st_e.
//  - line struct type_icache_nway_line_s {valid, tag, data_line}.
//  - Derived width functions/constants (OFF_W, IDX_W, TAG_W).
//  Sub-module icache_victim_sel (combinational): way valid vector + tag matches + rr_ptr -> hit, hit_way, victim_way.
//  Arrays: data[NUM_SETS][NUM_WAYS], tag/valid[NUM_SETS][NUM_WAYS], rr_ptr[NUM_SETS].
// TESTING (LINE_W=128, NUM_SETS=128, NUM_WAYS=2, set stride 0x800)
//  1 Reset: rst_i high 2 cycles, release -> ready_o=0 for exactly 128 cycles, then 1; data_valid_o/refill_req_o stay 0.
//  2 Cold miss addr 0x1004 -> next cycle refill_req_o=1, refill_addr_o=0x1000.
//    Ack with line words {W3..W0}={0xD,0xC,0xB,0xA} -> next cycle data_valid_o=1, hit_o=0, data_o=0xB.
//    Then lookup 0x1008 -> 1 cycle later hit_o=1, data_o=0xC.
//  3 Conflict: fill 0x1000, 0x1800, then 0x2000 (all set 0) -> 0x2000 evicts way0.
//    Lookup 0x1000 misses; 0x1800 hits; next miss in set 0 evicts way1.
//  4 flush_i pulse while in MISS awaiting ack -> reply still delivered.
//    Then ready_o=0 for 128 cycles; lookup 0x1000 afterwards misses.
//  5 Ack in same cycle refill_req_o rises -> data at +1; ack held high 3 extra cycles causes no extra writes/replies.
//  6 rst_i during MISS -> refill_req_o=0 next cycle, 128-cycle FLUSH; a late ack during FLUSH is ignored and later lookups miss.

Source files
------------

// File: rtl/icache_nway_datapath_pkg.sv
// ---------------------------------------------------------------------------
// icache_nway_datapath_pkg
// Shared definitions for the N-way instruction cache: the controller state
// type, the default cache geometry, helper functions that derive the address
// field widths from a geometry, and a packed line record for that default
// geometry.
// Ports: none (package).
// ---------------------------------------------------------------------------
package icache_nway_datapath_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LINE_W   = 128;
    localparam int DEF_NUM_SETS = 128;
    localparam int DEF_NUM_WAYS = 2;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_MISS,
        ST_REPLY
    } type_icache_nway_st_e;

    // Byte-offset bits inside one line
    function automatic int calc_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Set-index bits
    function automatic int calc_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Whatever is left of the address above index and offset is the tag
    function automatic int calc_tag_w(input int addr_w, input int line_w, input int num_sets);
        return addr_w - calc_idx_w(num_sets) - calc_off_w(line_w);
    endfunction

    // A direct-mapped cache still needs a 1-bit way index to keep vectors legal
    function automatic int calc_way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    localparam int OFF_W = calc_off_w(DEF_LINE_W);
    localparam int IDX_W = calc_idx_w(DEF_NUM_SETS);
    localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DEF_LINE_W-1:0] data_line;
    } type_icache_nway_line_s;

endpackage

// File: rtl/icache_nway_datapath_if.sv
// ---------------------------------------------------------------------------
// icache_nway_datapath_if
// Bundles the fetch-side lookup port and the imem-side refill port of the
// instruction cache.
//   slave  modport : the cache (takes lookups/acks, returns data/refill reqs)
//   master modport : fetch stage + imem model driving the cache
// Signals: flush_i, lookup_req_i, addr_i, ready_o, data_valid_o, hit_o,
//          data_o, refill_req_o, refill_addr_o, refill_ack_i, refill_data_i
// ---------------------------------------------------------------------------
interface icache_nway_datapath_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
);
    logic              flush_i;
    logic              lookup_req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              ready_o;
    logic              data_valid_o;
    logic              hit_o;
    logic [DATA_W-1:0] data_o;
    logic              refill_req_o;
    logic [ADDR_W-1:0] refill_addr_o;
    logic              refill_ack_i;
    logic [LINE_W-1:0] refill_data_i;

    modport slave (
        input  flush_i, lookup_req_i, addr_i, refill_ack_i, refill_data_i,
        output ready_o, data_valid_o, hit_o, data_o, refill_req_o, refill_addr_o
    );

    modport master (
        output flush_i, lookup_req_i, addr_i, refill_ack_i, refill_data_i,
        input  ready_o, data_valid_o, hit_o, data_o, refill_req_o, refill_addr_o
    );
endinterface

// File: rtl/icache_nway_datapath_victim_sel.sv
// ---------------------------------------------------------------------------
// icache_victim_sel
// Combinational way selection for one set.
//   way_valid  in  : valid bit of every way in the set
//   tag_match  in  : raw tag compare result of every way
//   rr_ptr     in  : round-robin pointer of the set
//   hit        out : some valid way matches
//   hit_way    out : lowest-numbered matching way
//   victim_way out : lowest invalid way, else the round-robin way
//   all_valid  out : every way valid, so the victim is a real eviction
// ---------------------------------------------------------------------------
module icache_victim_sel
    import icache_nway_datapath_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_W    = calc_way_w(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [NUM_WAYS-1:0] tag_match,
    input  logic [WAY_W-1:0]    rr_ptr,
    output logic                hit,
    output logic [WAY_W-1:0]    hit_way,
    output logic [WAY_W-1:0]    victim_way,
    output logic                all_valid
);

    // Walking from the top way down lets the lowest-numbered candidate win
    // both the hit search and the free-way search.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = rr_ptr;
        all_valid  = &way_valid;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && tag_match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_nway_datapath.sv
// ---------------------------------------------------------------------------
// icache_nway_datapath
// N-way set-associative instruction cache for the fetch stage: 1-cycle hit
// latency, line refill over a req/ack handshake, per-set round-robin
// replacement and a set-by-set flush walk after reset or on request.
//   clk_i  in : clock
//   rst_i  in : synchronous active-high reset (starts a full flush)
//   bus       : icache_nway_datapath_if.slave (lookup + refill ports)
// ---------------------------------------------------------------------------
module icache_nway_datapath
    import icache_nway_datapath_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LINE_W   = DEF_LINE_W,
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    icache_nway_datapath_if.slave   bus
);

    localparam int LINE_OFF_W = calc_off_w(LINE_W);
    localparam int SET_IDX_W  = calc_idx_w(NUM_SETS);
    localparam int LINE_TAG_W = calc_tag_w(ADDR_W, LINE_W, NUM_SETS);
    localparam int WAY_W      = calc_way_w(NUM_WAYS);
    localparam int WORDS      = LINE_W / DATA_W;
    localparam int BYTE_SH    = $clog2(DATA_W / 8);

    // Storage is never reset; only the valid bits are trusted
    logic [LINE_W-1:0]     data_arr  [NUM_SETS][NUM_WAYS];
    logic [LINE_TAG_W-1:0] tag_arr   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_arr [NUM_SETS];
    logic [WAY_W-1:0]      rr_arr    [NUM_SETS];

    type_icache_nway_st_e  state;
    logic [SET_IDX_W-1:0]  flush_idx;
    logic                  flush_pend;
    logic [ADDR_W-1:0]     req_addr;

    logic [SET_IDX_W-1:0]  look_idx;
    logic [SET_IDX_W-1:0]  sel_idx;
    logic [NUM_WAYS-1:0]   tag_match;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_way;
    logic                  all_valid;

    function automatic logic [SET_IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[LINE_OFF_W +: SET_IDX_W];
    endfunction

    function automatic logic [LINE_TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: LINE_TAG_W];
    endfunction

    // Word 0 sits in the least significant bits of the line
    function automatic logic [DATA_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                   input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] sel;
        sel = (a >> BYTE_SH) & ADDR_W'(WORDS - 1);
        return DATA_W'(line >> (sel * ADDR_W'(DATA_W)));
    endfunction

    // In IDLE the set comes straight from the incoming address so the hit
    // answer is ready by the accepting edge; during a refill the latched
    // request address picks the set that receives the line.
    assign look_idx = idx_of(bus.addr_i);
    assign sel_idx  = (state == ST_IDLE) ? look_idx : idx_of(req_addr);

    always_comb begin
        tag_match = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            tag_match[w] = (tag_arr[sel_idx][w] == tag_of(bus.addr_i));
        end
    end

    icache_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim_sel (
        .way_valid  (valid_arr[sel_idx]),
        .tag_match  (tag_match),
        .rr_ptr     (rr_arr[sel_idx]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .all_valid  (all_valid)
    );

    // Controller, array writes and registered outputs. Reset wins over any
    // ack arriving in the same cycle, so an abandoned refill never lands.
    // A flush seen while a refill is in flight is parked in flush_pend and
    // honoured once the reply has gone out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_FLUSH;
            flush_idx         <= '0;
            flush_pend        <= 1'b0;
            req_addr          <= '0;
            bus.ready_o       <= 1'b0;
            bus.data_valid_o  <= 1'b0;
            bus.hit_o         <= 1'b0;
            bus.data_o        <= '0;
            bus.refill_req_o  <= 1'b0;
            bus.refill_addr_o <= '0;
        end else begin
            bus.data_valid_o <= 1'b0;
            bus.hit_o        <= 1'b0;
            case (state)
                ST_FLUSH: begin
                    valid_arr[flush_idx] <= '0;
                    rr_arr[flush_idx]    <= '0;
                    flush_idx            <= flush_idx + 1'b1;
                    flush_pend           <= 1'b0;
                    if (flush_idx == SET_IDX_W'(NUM_SETS - 1)) begin
                        state       <= ST_IDLE;
                        bus.ready_o <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.flush_i) begin
                        state       <= ST_FLUSH;
                        flush_idx   <= '0;
                        bus.ready_o <= 1'b0;
                    end else if (bus.lookup_req_i) begin
                        req_addr <= bus.addr_i;
                        if (hit) begin
                            bus.data_valid_o <= 1'b1;
                            bus.hit_o        <= 1'b1;
                            bus.data_o       <= word_of(data_arr[sel_idx][hit_way], bus.addr_i);
                        end else begin
                            state             <= ST_MISS;
                            bus.ready_o       <= 1'b0;
                            bus.refill_req_o  <= 1'b1;
                            bus.refill_addr_o <= {tag_of(bus.addr_i), look_idx, LINE_OFF_W'(0)};
                        end
                    end
                end
                ST_MISS: begin
                    if (bus.flush_i) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.refill_ack_i) begin
                        data_arr[sel_idx][victim_way]  <= bus.refill_data_i;
                        tag_arr[sel_idx][victim_way]   <= tag_of(req_addr);
                        valid_arr[sel_idx][victim_way] <= 1'b1;
                        if (all_valid) begin
                            rr_arr[sel_idx] <= (rr_arr[sel_idx] == WAY_W'(NUM_WAYS - 1)) ?
                                               '0 : rr_arr[sel_idx] + 1'b1;
                        end
                        bus.refill_req_o <= 1'b0;
                        bus.data_valid_o <= 1'b1;
                        bus.data_o       <= word_of(bus.refill_data_i, req_addr);
                        state            <= ST_REPLY;
                    end
                end
                ST_REPLY: begin
                    if (flush_pend || bus.flush_i) begin
                        state      <= ST_FLUSH;
                        flush_idx  <= '0;
                        flush_pend <= 1'b0;
                    end else begin
                        state       <= ST_IDLE;
                        bus.ready_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_FLUSH;
                    flush_idx <= '0;
                end
            endcase
        end
    end

    // Two ways holding the same tag in one set means the fill logic broke
    assert property (@(posedge clk_i) disable iff (rst_i)
        (state == ST_IDLE && bus.lookup_req_i) |-> $onehot0(valid_arr[sel_idx] & tag_match));

endmodule

// File: tb/tb_icache_nway_datapath.sv
// ---------------------------------------------------------------------------
// tb_icache_nway_datapath
// Self-checking bench for icache_nway_datapath (128-bit lines, 128 sets,
// 2 ways, set stride 0x800). A transaction-level cache model predicts every
// output each cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_icache_nway_datapath;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int LINE_W   = 128;
    localparam int NUM_SETS = 128;
    localparam int NUM_WAYS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    icache_nway_datapath_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) bus ();

    icache_nway_datapath #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LINE_W   (LINE_W),
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Model state: cache contents plus what the outputs must show
    bit           m_valid [NUM_SETS][NUM_WAYS];
    logic [31:0]  m_tag   [NUM_SETS][NUM_WAYS];
    logic [127:0] m_line  [NUM_SETS][NUM_WAYS];
    int           m_rr    [NUM_SETS];
    int           flush_left = 0;
    bit           in_miss = 0;
    bit           in_reply = 0;
    bit           pend = 0;
    bit           started = 0;
    logic [31:0]  miss_addr = '0;
    logic         exp_ready = 1'b0;
    logic         exp_dv = 1'b0;
    logic         exp_hit = 1'b0;
    logic         exp_req = 1'b0;
    logic [31:0]  exp_data = '0;
    logic [31:0]  exp_raddr = '0;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h7F);
    endfunction

    function automatic logic [31:0] tag_val(input logic [31:0] a);
        return a >> 11;
    endfunction

    function automatic logic [31:0] word_in(input logic [127:0] line, input logic [31:0] a);
        int w;
        w = int'((a >> 2) & 32'h3);
        return line[w*32 +: 32];
    endfunction

    // Each word holds its own byte address, so any fetched word must equal addr & ~3
    function automatic logic [127:0] line_for(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'hF;
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    function automatic int find_way(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == tag_val(a)) return w;
        end
        return -1;
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [127:0] line);
        int s;
        int v;
        s = set_of(a);
        v = -1;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!m_valid[s][w] && v < 0) v = w;
        end
        if (v < 0) begin
            v       = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NUM_WAYS;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = tag_val(a);
        m_line[s][v]  = line;
    endfunction

    // Lookups are impossible until the walk is done, so clearing everything at once is equivalent
    function automatic void model_flush();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) m_valid[s][w] = 1'b0;
        end
        flush_left = NUM_SETS;
    endfunction

    // Model advance: sees the same inputs the DUT samples on this edge
    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            model_flush();
            in_miss = 0; in_reply = 0; pend = 0;
            exp_ready = 0; exp_dv = 0; exp_hit = 0; exp_req = 0;
            exp_data = '0; exp_raddr = '0;
        end else begin
            exp_dv  = 0;
            exp_hit = 0;
            if (flush_left > 0) begin
                flush_left--;
                if (flush_left == 0) exp_ready = 1;
            end else if (in_reply) begin
                in_reply = 0;
                if (pend || bus.flush_i) begin
                    pend = 0;
                    model_flush();
                end else begin
                    exp_ready = 1;
                end
            end else if (in_miss) begin
                if (bus.flush_i) pend = 1;
                if (bus.refill_ack_i) begin
                    model_fill(miss_addr, bus.refill_data_i);
                    exp_dv   = 1;
                    exp_data = word_in(bus.refill_data_i, miss_addr);
                    exp_req  = 0;
                    in_miss  = 0;
                    in_reply = 1;
                end
            end else if (bus.flush_i) begin
                model_flush();
                exp_ready = 0;
            end else if (bus.lookup_req_i) begin
                int way;
                way = find_way(bus.addr_i);
                if (way >= 0) begin
                    exp_dv   = 1;
                    exp_hit  = 1;
                    exp_data = word_in(m_line[set_of(bus.addr_i)][way], bus.addr_i);
                end else begin
                    in_miss   = 1;
                    miss_addr = bus.addr_i;
                    exp_req   = 1;
                    exp_raddr = bus.addr_i & ~32'hF;
                    exp_ready = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            checkOutput("ready_o", bus.ready_o, exp_ready);
            checkOutput("data_valid_o", bus.data_valid_o, exp_dv);
            checkOutput("hit_o", bus.hit_o, exp_hit);
            checkOutput("data_o", bus.data_o, exp_data);
            checkOutput("refill_req_o", bus.refill_req_o, exp_req);
            if (exp_req) checkOutput("refill_addr_o", bus.refill_addr_o, exp_raddr);
        end
    end

    // Issue one lookup once the cache is ready; returns at the negedge after acceptance
    task automatic applyStimulus(input logic [31:0] a);
        int n;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready_o !== 1'b1) checkOutput("ready_timeout", bus.ready_o, 1);
        bus.addr_i       = a;
        bus.lookup_req_i = 1'b1;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
    endtask

    // Answer a pending refill after delay cycles; returns at the reply negedge
    task automatic serve_refill(input logic [127:0] line, input int delay);
        int n;
        n = 0;
        while (bus.refill_req_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.refill_req_o !== 1'b1) checkOutput("refill_timeout", bus.refill_req_o, 1);
        repeat (delay) @(negedge clk);
        bus.refill_data_i = line;
        bus.refill_ack_i  = 1'b1;
        @(negedge clk);
        bus.refill_ack_i  = 1'b0;
    endtask

    task automatic fetch_expect(input logic [31:0] a, input bit exp_is_hit);
        applyStimulus(a);
        checkOutput($sformatf("hit_%0h", a), bus.data_valid_o & bus.hit_o, exp_is_hit);
        if (bus.refill_req_o === 1'b1) serve_refill(line_for(a), 0);
        checkOutput($sformatf("word_%0h", a), bus.data_o, a & ~32'h3);
    endtask

    // Count negedges with ready_o low, bounded
    task automatic count_not_ready(output int n);
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bus.flush_i       = 1'b0;
        bus.lookup_req_i  = 1'b0;
        bus.addr_i        = '0;
        bus.refill_ack_i  = 1'b0;
        bus.refill_data_i = '0;

        // Reset then the 128-cycle flush walk
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_not_ready(n);
        checkOutput("reset_flush_len", n, 128);

        // Cold miss, refill, then hit on a neighbouring word
        applyStimulus(32'h1004);
        checkOutput("cold_req", bus.refill_req_o, 1);
        checkOutput("cold_raddr", bus.refill_addr_o, 32'h1000);
        serve_refill({32'hD, 32'hC, 32'hB, 32'hA}, 0);
        checkOutput("cold_dv", bus.data_valid_o, 1);
        checkOutput("cold_hit", bus.hit_o, 0);
        checkOutput("cold_data", bus.data_o, 32'hB);
        applyStimulus(32'h1008);
        checkOutput("warm_hit", bus.hit_o, 1);
        checkOutput("warm_data", bus.data_o, 32'hC);

        // Conflicts in set 0 exercising round-robin eviction
        fetch_expect(32'h1800, 0);
        fetch_expect(32'h2000, 0);
        fetch_expect(32'h1800, 1);
        fetch_expect(32'h1000, 0);
        fetch_expect(32'h2000, 1);
        fetch_expect(32'h1800, 0);
        fetch_expect(32'h1000, 1);

        // Flush while waiting for the ack: reply still delivered, then flush
        applyStimulus(32'h3000);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        serve_refill(line_for(32'h3000), 0);
        checkOutput("flushmiss_dv", bus.data_valid_o, 1);
        checkOutput("flushmiss_data", bus.data_o, 32'h3000);
        @(negedge clk);
        count_not_ready(n);
        checkOutput("pending_flush_len", n, 128);
        fetch_expect(32'h1000, 0);

        // Ack in the first miss cycle and held high afterwards
        applyStimulus(32'h4010);
        bus.refill_data_i = line_for(32'h4010);
        bus.refill_ack_i  = 1'b1;
        @(negedge clk);
        checkOutput("fastack_dv", bus.data_valid_o, 1);
        checkOutput("fastack_data", bus.data_o, 32'h4010);
        repeat (3) @(negedge clk);
        bus.refill_ack_i = 1'b0;
        fetch_expect(32'h4010, 1);
        fetch_expect(32'h4014, 1);

        // Reset during a miss abandons the refill; a late ack is ignored
        applyStimulus(32'h5000);
        checkOutput("rst_miss_req", bus.refill_req_o, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("req_after_rst", bus.refill_req_o, 0);
        rst = 1'b0;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 400) begin
            if (n == 5) begin
                bus.refill_data_i = line_for(32'h5000);
                bus.refill_ack_i  = 1'b1;
            end
            if (n == 8) bus.refill_ack_i = 1'b0;
            n++;
            @(negedge clk);
        end
        bus.refill_ack_i = 1'b0;
        checkOutput("rst_flush_len", n, 128);
        fetch_expect(32'h5000, 0);
        fetch_expect(32'h1800, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
